key_schedule_seq: RTL and testbench

Iterative AES key expansion engine, parametrised for AES-128/192/256. Generates one 32-bit schedule word per clock into internal word storage, replacing the fully unrolled combinational chain. The cipher datapath fetches any round key by index through a combinational read port. It sits between the key-load interface and the round datapath; its area is one word-generator plus storage.

---
 rtl/key_schedule_seq.sv | 164 ++++++++++++++++
 tb/tb_key_schedule_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: iterative AES-128/192/256 key expansion.
// One 32-bit schedule word is produced per clock into a word array. Any
// round key is read combinationally by index.
// Optional build macro KS_ZEROIZE_EN adds a zeroize input and a WIPE state
// that clears the array one word per clock.
module key_schedule_seq #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                key_valid,
  input  logic [KEY_BITS-1:0] key_in,
`ifdef KS_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic [3:0]          rk_idx,
  output logic                busy,
  output logic                keys_ready,
  output logic [127:0]        rk_out,
  output logic [1:0]          dbg_state
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK6    = 6'(NK);
  localparam logic [5:0] NW_M1  = 6'(NW - 1);
  localparam logic [2:0] NK_M1  = 3'(NK - 1);
  localparam logic [3:0] NR4    = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_schedule_seq: KEY_BITS must be 128, 192 or 256");
  end

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2,
    S_WIPE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [NW];
  logic [5:0]  i_q;
  // rem_q == 0 marks i mod NK == 0; otherwise i mod NK == NK - rem_q.
  logic [2:0]  rem_q;
  logic [7:0]  rcon_q;

  logic        zero_req;
  logic        last_word;
  logic [31:0] prev_word, old_word, t_word, new_word;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

`ifdef KS_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign last_word = (i_q == NW_M1);
  assign prev_word = w_q[i_q - 6'd1];
  assign old_word  = w_q[i_q - NK6];

  // Word generator: the t term chosen by position within the key period.
  always_comb begin
    t_word = prev_word;
    if (rem_q == 3'd0) begin
      t_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon_q, 24'h0};
    end else if (NK == 8 && rem_q == 3'd4) begin
      t_word = sub_word(prev_word);
    end
    new_word = old_word ^ t_word;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; zeroize overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_READY: if (key_valid) state_d = S_EXPAND;
      S_EXPAND:        if (last_word) state_d = S_READY;
      S_WIPE:          if (last_word) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
    if (zero_req) state_d = S_WIPE;
  end

  // Outputs decoded from state.
  always_comb begin
    busy       = (state_q == S_EXPAND) || (state_q == S_WIPE);
    keys_ready = (state_q == S_READY);
    dbg_state  = state_q;
  end

  // Word storage, word counter, period down-counter and round constant.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NW; k++) w_q[k] <= 32'h0;
      i_q    <= 6'd0;
      rem_q  <= 3'd0;
      rcon_q <= 8'h01;
    end else if (zero_req) begin
      i_q <= 6'd0;
    end else begin
      unique case (state_q)
        S_IDLE, S_READY: begin
          if (key_valid) begin
            for (int k = 0; k < NK; k++) w_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
            i_q    <= NK6;
            rem_q  <= 3'd0;
            rcon_q <= 8'h01;
          end
        end
        S_EXPAND: begin
          w_q[i_q] <= new_word;
          rem_q    <= (rem_q == 3'd0) ? NK_M1 : rem_q - 3'd1;
          if (rem_q == 3'd0) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          if (!last_word) i_q <= i_q + 6'd1;
        end
        S_WIPE: begin
          w_q[i_q] <= 32'h0;
          if (!last_word) i_q <= i_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Round-key read port; indices past the last round read as zero.
  always_comb begin
    logic [5:0] base;
    base   = {rk_idx, 2'b00};
    rk_out = 128'h0;
    if (rk_idx <= NR4) begin
      rk_out = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
    end
  end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Testbench for key_schedule_seq: FIPS-197 key expansion vectors for all
// three key sizes, load protocol, reset and (when built with KS_ZEROIZE_EN)
// the wipe path.
module tb_key_schedule_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic n_rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic         kv128, kv192, kv256;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [3:0]   idx128, idx192, idx256;
  logic         busy128, busy192, busy256;
  logic         rdy128, rdy192, rdy256;
  logic [127:0] rk128, rk192, rk256;
  logic [1:0]   st128, st192, st256;
`ifdef KS_ZEROIZE_EN
  logic         zer128;
  logic         zer_off;
`endif

  key_schedule_seq #(.KEY_BITS(128)) dut128 (
    .clk(clk), .n_rst(n_rst), .key_valid(kv128), .key_in(key128),
`ifdef KS_ZEROIZE_EN
    .zeroize(zer128),
`endif
    .rk_idx(idx128), .busy(busy128), .keys_ready(rdy128), .rk_out(rk128), .dbg_state(st128)
  );

  key_schedule_seq #(.KEY_BITS(192)) dut192 (
    .clk(clk), .n_rst(n_rst), .key_valid(kv192), .key_in(key192),
`ifdef KS_ZEROIZE_EN
    .zeroize(zer_off),
`endif
    .rk_idx(idx192), .busy(busy192), .keys_ready(rdy192), .rk_out(rk192), .dbg_state(st192)
  );

  key_schedule_seq #(.KEY_BITS(256)) dut256 (
    .clk(clk), .n_rst(n_rst), .key_valid(kv256), .key_in(key256),
`ifdef KS_ZEROIZE_EN
    .zeroize(zer_off),
`endif
    .rk_idx(idx256), .busy(busy256), .keys_ready(rdy256), .rk_out(rk256), .dbg_state(st256)
  );

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic ready_of(input int sel);
    if (sel == 0) return rdy128;
    if (sel == 1) return rdy192;
    return rdy256;
  endfunction

  // Counts clock edges until keys_ready is seen, bounded.
  task automatic wait_ready(input int sel, output int edges);
    edges = 0;
    while (!ready_of(sel) && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Leaves the bench on the negedge right after the load edge.
  task automatic load128(input logic [127:0] k);
    @(negedge clk);
    key128 = k;
    kv128  = 1'b1;
    @(negedge clk);
    kv128  = 1'b0;
  endtask

  task automatic read128(input logic [3:0] idx, output logic [127:0] v);
    idx128 = idx;
    #1;
    v = rk128;
  endtask

  // Pops expected round keys and compares them against successive indices.
  task automatic drain128(input string tag, input logic [3:0] idx_list [2]);
    logic [127:0] v;
    for (int n = 0; n < 2; n++) begin
      read128(idx_list[n], v);
      check($sformatf("%s_rk%0d", tag, idx_list[n]), v, exp_q.pop_front());
    end
  endtask

  localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- main sequence ----------------
  initial begin
    int edges;
    int pre;
    logic [127:0] v;
    logic [127:0] acc;
    logic [3:0]   pair [2];

    checks = 0;
    errors = 0;
    kv128 = 1'b0; kv192 = 1'b0; kv256 = 1'b0;
    key128 = '0; key192 = '0; key256 = '0;
    idx128 = 4'd0; idx192 = 4'd0; idx256 = 4'd0;
`ifdef KS_ZEROIZE_EN
    zer128  = 1'b0;
    zer_off = 1'b0;
`endif

    // Reset state
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {127'h0, busy128}, 128'h0);
    check("rst_ready", {127'h0, rdy128}, 128'h0);
    check("rst_state", {126'h0, st128}, 128'h0);
    read128(4'd0, v);
    check("rst_rk0", v, 128'h0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // AES-128 expansion
    load128(K128);
    check("k128_busy", {127'h0, busy128}, 128'h1);
    wait_ready(0, edges);
    check("k128_latency", 128'(edges), 128'd40);
    check("k128_busy_done", {127'h0, busy128}, 128'h0);
    read128(4'd0, v);
    check("k128_rk0", v, K128);
    exp_q.push_back(128'ha0fafe1788542cb123a339392a6c7605);
    exp_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    pair[0] = 4'd1; pair[1] = 4'd10;
    drain128("k128", pair);
    read128(4'd11, v);
    check("k128_rk11_zero", v, 128'h0);
    read128(4'd15, v);
    check("k128_rk15_zero", v, 128'h0);

    // AES-192 expansion
    @(negedge clk);
    key192 = K192;
    kv192  = 1'b1;
    @(negedge clk);
    kv192  = 1'b0;
    wait_ready(1, edges);
    check("k192_latency", 128'(edges), 128'd46);
    idx192 = 4'd0;
    #1;
    check("k192_rk0", rk192, 128'h8e73b0f7da0e6452c810f32b809079e5);
    idx192 = 4'd12;
    #1;
    check("k192_rk12", rk192, 128'he98ba06f448c773c8ecc720401002202);
    idx192 = 4'd13;
    #1;
    check("k192_rk13_zero", rk192, 128'h0);

    // AES-256 expansion (exercises the i mod 8 == 4 SubWord path)
    @(negedge clk);
    key256 = K256;
    kv256  = 1'b1;
    @(negedge clk);
    kv256  = 1'b0;
    wait_ready(2, edges);
    check("k256_latency", 128'(edges), 128'd52);
    idx256 = 4'd1;
    #1;
    check("k256_rk1", rk256, 128'h1f352c073b6108d72d9810a30914dff4);
    idx256 = 4'd14;
    #1;
    check("k256_rk14", rk256, 128'hfe4890d1e6188d0b046df344706c631e);
    idx256 = 4'd15;
    #1;
    check("k256_rk15_zero", rk256, 128'h0);

    // key_valid during EXPAND is ignored
    load128(K128);
    repeat (9) @(negedge clk);
    key128 = K128_B;
    kv128  = 1'b1;
    @(negedge clk);
    kv128  = 1'b0;
    pre = 10;
    wait_ready(0, edges);
    check("ignore_latency", 128'(pre + edges), 128'd40);
    read128(4'd10, v);
    check("ignore_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reload from READY drops keys_ready on the load edge
    load128(K128_B);
    check("reload_ready_drop", {127'h0, rdy128}, 128'h0);
    wait_ready(0, edges);
    check("reload_latency", 128'(edges), 128'd40);
    read128(4'd10, v);
    check("reload_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Asynchronous reset in the middle of EXPAND
    load128(K128);
    repeat (19) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_busy", {127'h0, busy128}, 128'h0);
    check("midrst_ready", {127'h0, rdy128}, 128'h0);
    acc = '0;
    for (int r = 0; r <= 10; r++) begin
      read128(4'(r), v);
      acc = acc | v;
    end
    check("midrst_all_rk_zero", acc, 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    load128(K128);
    wait_ready(0, edges);
    check("postrst_latency", 128'(edges), 128'd40);
    read128(4'd1, v);
    check("postrst_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);

`ifdef KS_ZEROIZE_EN
    // Zeroize from READY: WIPE for 44 edges, then IDLE with empty storage
    @(negedge clk);
    zer128 = 1'b1;
    @(negedge clk);
    zer128 = 1'b0;
    check("zer_busy", {127'h0, busy128}, 128'h1);
    check("zer_ready", {127'h0, rdy128}, 128'h0);
    edges = 0;
    while (busy128 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check("zer_wipe_len", 128'(edges), 128'd44);
    check("zer_idle", {126'h0, st128}, 128'h0);
    acc = '0;
    for (int r = 0; r <= 10; r++) begin
      read128(4'(r), v);
      acc = acc | v;
    end
    check("zer_all_rk_zero", acc, 128'h0);

    // zeroize wins over key_valid on the same edge
    load128(K128);
    wait_ready(0, edges);
    @(negedge clk);
    key128 = K128_B;
    kv128  = 1'b1;
    zer128 = 1'b1;
    @(negedge clk);
    kv128  = 1'b0;
    zer128 = 1'b0;
    check("zer_prio_state", {126'h0, st128}, 128'h3);
    edges = 0;
    while (busy128 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    check("zer_prio_wipe_len", 128'(edges), 128'd44);
    read128(4'd0, v);
    check("zer_prio_rk0", v, 128'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
